caliptra_log_fifo: RTL and testbench



---
 rtl/caliptra_log_fifo.sv | 107 ++++++++++
 tb/tb_caliptra_log_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/caliptra_log_fifo.sv
// rtl/caliptra_log_fifo.sv - byte log circular buffer with host pop, status and sticky overflow
// Optional CALIPTRA_LOG_FIFO_DROP_OLDEST_EN: a push into a full buffer overwrites the oldest byte.
module caliptra_log_fifo #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             core_clk,
    input  logic             cptra_rst_b,
    input  logic             fifo_write_en,
    input  logic [7:0]       fifo_char,
    input  logic             log_rd_en,
    input  logic             log_clr,
    output logic [7:0]       log_rd_data,
    output logic             log_rd_valid,
    output logic             log_empty,
    output logic             log_full,
    output logic [CNT_W-1:0] log_count,
    output logic             log_overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;

    logic pop, push, ovf_hit, overwrite, mem_we;

    always_comb begin
        pop     = log_rd_en && !empty_q;
        push    = fifo_write_en && (!full_q || pop);
        ovf_hit = fifo_write_en && full_q && !pop;
`ifdef CALIPTRA_LOG_FIFO_DROP_OLDEST_EN
        overwrite = ovf_hit;
`else
        overwrite = 1'b0;
`endif
        mem_we = !log_clr && (push || overwrite);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;

        // Flush wins over everything; the last popped byte stays visible.
        if (log_clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (mem_we) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop || overwrite) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (ovf_hit) overflow_d = 1'b1;
            if (pop) begin
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge core_clk) begin
        if (mem_we) mem[wr_ptr_q] <= fifo_char;
    end

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign log_rd_data  = rd_data_q;
    assign log_rd_valid = rd_valid_q;
    assign log_empty    = empty_q;
    assign log_full     = full_q;
    assign log_count    = count_q;
    assign log_overflow = overflow_q;
endmodule

// File: tb/tb_caliptra_log_fifo.sv
// tb/tb_caliptra_log_fifo.sv - queue-model checked bench for caliptra_log_fifo (DEPTH=4)
module tb_caliptra_log_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             we, rd, clr;
    logic [7:0]       ch;
    logic [7:0]       rd_data;
    logic             rd_valid, empty, full, ovf;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] m_data;
    logic       m_valid, m_ovf;
    logic [7:0] popped[$];

    always #5 clk = ~clk;

    caliptra_log_fifo #(.DEPTH(DEPTH)) dut (
        .core_clk(clk), .cptra_rst_b(rst_n),
        .fifo_write_en(we), .fifo_char(ch), .log_rd_en(rd), .log_clr(clr),
        .log_rd_data(rd_data), .log_rd_valid(rd_valid), .log_empty(empty),
        .log_full(full), .log_count(count), .log_overflow(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a plain byte queue; pop takes the front, push appends if there is room.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else if (clr) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (rd && mq.size() > 0) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back(ch);
                else begin
                    m_ovf = 1'b1;
`ifdef CALIPTRA_LOG_FIFO_DROP_OLDEST_EN
                    void'(mq.pop_front());
                    mq.push_back(ch);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_valid", rd_valid, m_valid);
            chk("rd_data", rd_data, m_data);
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("count", count, mq.size());
            chk("overflow", ovf, m_ovf);
            if (rd_valid) popped.push_back(rd_data);
        end
    end

    task automatic step(input bit w, input logic [7:0] c, input bit r, input bit l);
        we = w; ch = c; rd = r; clr = l;
        @(negedge clk);
        #1;
        we = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp3 [4];
        rst_n = 1'b0; we = 1'b0; rd = 1'b0; clr = 1'b0; ch = 8'h00;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("reset_empty", empty, 1);
        chk("reset_count", count, 0);
        chk("reset_valid", rd_valid, 0);

        step(0, 8'h00, 1, 0);
        chk("pop_empty_no_valid", rd_valid, 0);

        step(1, 8'h48, 0, 0);
        step(1, 8'h69, 0, 0);
        step(1, 8'h0A, 0, 0);
        popped.delete();
        repeat (3) step(0, 8'h00, 1, 0);
        chk("hi_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("hi_b0", popped[0], 8'h48);
            chk("hi_b1", popped[1], 8'h69);
            chk("hi_b2", popped[2], 8'h0A);
        end
        chk("hi_empty", empty, 1);

        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h41 + i), 0, 0);
        chk("ovf_full", full, 1);
        chk("ovf_flag", ovf, 1);
`ifdef CALIPTRA_LOG_FIFO_DROP_OLDEST_EN
        exp3 = '{8'h42, 8'h43, 8'h44, 8'h45};
`else
        exp3 = '{8'h41, 8'h42, 8'h43, 8'h44};
`endif
        popped.delete();
        repeat (4) step(0, 8'h00, 1, 0);
        chk("ovf_pops", popped.size(), 4);
        if (popped.size() == 4)
            for (int i = 0; i < 4; i++) chk("ovf_byte", popped[i], exp3[i]);

        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h61 + i), 0, 0);
        popped.delete();
        step(1, 8'h5A, 1, 0);
        chk("fullpp_count", count, 4);
        chk("fullpp_ovf", ovf, 0);
        chk("fullpp_first", popped.size() > 0 ? popped[0] : 8'hxx, 8'h61);
        repeat (4) step(0, 8'h00, 1, 0);
        chk("fullpp_pops", popped.size(), 5);
        if (popped.size() == 5) chk("fullpp_last", popped[4], 8'h5A);

        step(0, 8'h00, 0, 1);
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'h30 + i), i > 0, 0);
            chk("wrap_count_le1", count <= 1, 1);
        end
        step(0, 8'h00, 1, 0);
        chk("wrap_pops", popped.size(), 10);
        if (popped.size() == 10)
            for (int i = 0; i < 10; i++) chk("wrap_byte", popped[i], 8'h30 + i);

        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), 0, 0);
        step(0, 8'h00, 1, 0);
        chk("pre_clr_count", count, 3);
        chk("pre_clr_ovf", ovf, 1);
        step(1, 8'h77, 0, 1);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_ovf", ovf, 0);
        popped.delete();
        step(0, 8'h00, 1, 0);
        chk("clr_byte_dropped", popped.size(), 0);

        step(1, 8'h11, 0, 0);
        we = 1'b1; ch = 8'h99;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", rd_data, 8'h00);
        chk("rst_valid", rd_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        we = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 63) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
